// File: rtl/hyper_pkg.sv
// rtl/hyper_pkg.sv - shared types and constants for the HyperBus memory responder
package hyper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_RD,
    ST_WR,
    ST_REGWR
  } hyper_state_e;

  localparam int CA_RW = 47;
  localparam int CA_AS = 46;
  localparam int CA_BT = 45;

  localparam logic [15:0] CFG_RST = 16'h8F1F;

  typedef struct packed {
    logic       hyper_cs0_no;
    logic       hyper_cs1_no;
    logic       hyper_ck_o;
    logic       hyper_rwds_o;
    logic       hyper_rwds_oe_o;
    logic       hyper_reset_no;
    logic [7:0] hyper_dq_o;
    logic       hyper_dq_oe_o;
  } hyper_to_pad_t;

  typedef struct packed {
    logic       hyper_rwds_i;
    logic [7:0] hyper_dq_i;
  } pad_to_hyper_t;

  // Wrapped bursts stay inside the aligned 16-word group.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic linear);
    if (linear) return a + 32'd1;
    return {a[31:4], a[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/hyper_resp_mem.sv
// rtl/hyper_resp_mem.sv - single-port word RAM with byte enables and registered read
module hyper_resp_mem #(
  parameter int WORDS = 512,
  parameter int AW    = 9
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [WORDS];

  always_ff @(posedge clk_i) begin
    if (we) begin
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
      if (be[0]) mem[addr][7:0]  <= wdata[7:0];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/hyper_mem_responder.sv
// rtl/hyper_mem_responder.sv - HyperRAM device emulator on the controller pad interface
// Optional variable latency under HYPER_RESP_VARLAT_EN.
module hyper_mem_responder
  import hyper_pkg::*;
#(
  parameter int          MEM_WORDS      = 512,
  parameter int          LATENCY        = 6,
  parameter int          CS_SEL         = 0,
  parameter logic [15:0] ID0_VAL        = 16'h0C81,
  parameter int          REFRESH_PERIOD = 256
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  hyper_to_pad_t hyper_i,
  output pad_to_hyper_t hyper_o,
  output logic          dev_rwds_oe_o,
  output logic          dev_dq_oe_o,
  output logic          busy_o
);

  localparam int AW = $clog2(MEM_WORDS);

  hyper_state_e state, state_d;
  logic        ck_q, rise, fall, cs_n, abort, lat2x;
  logic [39:0] ca;
  logic [47:0] ca_nxt;
  logic [2:0]  byte_cnt;
  logic [7:0]  lat_cnt, lat_target;
  logic [31:0] addr;
  logic        is_read, is_reg, is_lin;
  logic [7:0]  wr_hi, dq_q;
  logic        wr_mask_hi, rwds_q;
  logic [15:0] cfg, mem_rdata, rd_word;
  logic        mem_we;
  logic [7:0]  dq_in;
  logic        rwds_in;

  assign dq_in   = hyper_i.hyper_dq_o;
  assign rwds_in = hyper_i.hyper_rwds_o;
  assign cs_n    = (CS_SEL == 0) ? hyper_i.hyper_cs0_no : hyper_i.hyper_cs1_no;
  assign abort   = cs_n | ~hyper_i.hyper_reset_no;
  assign rise    = hyper_i.hyper_ck_o & ~ck_q;
  assign fall    = ~hyper_i.hyper_ck_o & ck_q;
  assign ca_nxt  = {ca, dq_in};
  assign lat_target = lat2x ? 8'(2 * LATENCY) : 8'(LATENCY);

`ifdef HYPER_RESP_VARLAT_EN
  localparam int RW = $clog2(REFRESH_PERIOD);
  logic [RW-1:0] ref_cnt;
  logic          lat2x_q;

  // The latency mode is frozen for the whole transaction at the CS falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ref_cnt <= '0;
      lat2x_q <= 1'b1;
    end else begin
      ref_cnt <= (ref_cnt == RW'(REFRESH_PERIOD - 1)) ? '0 : ref_cnt + 1'b1;
      if (state == ST_IDLE && !abort) lat2x_q <= cfg[3] | (ref_cnt < RW'(16));
    end
  end
  assign lat2x = lat2x_q;
`else
  localparam int unused_refresh_period = REFRESH_PERIOD;
  assign lat2x = 1'b1;
`endif

  logic unused_bits;
  assign unused_bits = ^{hyper_i.hyper_rwds_oe_o, hyper_i.hyper_dq_oe_o, ca_nxt[15:3]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (abort) state_d = ST_IDLE;
    else begin
      case (state)
        ST_IDLE: state_d = ST_CA;
        ST_CA:   if ((rise || fall) && byte_cnt == 3'd5)
                   state_d = (!ca_nxt[CA_RW] && ca_nxt[CA_AS]) ? ST_REGWR : ST_LAT;
        ST_LAT:  if (fall && lat_cnt == lat_target) state_d = is_read ? ST_RD : ST_WR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ck_q       <= 1'b0;
      ca         <= '0;
      byte_cnt   <= '0;
      lat_cnt    <= '0;
      addr       <= '0;
      is_read    <= 1'b0;
      is_reg     <= 1'b0;
      is_lin     <= 1'b0;
      wr_hi      <= '0;
      wr_mask_hi <= 1'b0;
      cfg        <= CFG_RST;
      dq_q       <= '0;
      rwds_q     <= 1'b0;
    end else begin
      ck_q <= hyper_i.hyper_ck_o;
      if (state != ST_RD) begin
        dq_q   <= '0;
        rwds_q <= 1'b0;
      end
      if (abort || state == ST_IDLE) begin
        byte_cnt <= '0;
        lat_cnt  <= '0;
      end else begin
        case (state)
          ST_CA: if (rise || fall) begin
            ca       <= ca_nxt[39:0];
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd5) begin
              is_read  <= ca_nxt[CA_RW];
              is_reg   <= ca_nxt[CA_AS];
              is_lin   <= ca_nxt[CA_BT];
              addr     <= {ca_nxt[44:16], ca_nxt[2:0]};
              byte_cnt <= '0;
              lat_cnt  <= '0;
            end
          end
          ST_LAT: if (rise) lat_cnt <= lat_cnt + 8'd1;
          ST_RD: begin
            if (rise) begin
              dq_q   <= rd_word[15:8];
              rwds_q <= 1'b1;
            end else if (fall) begin
              dq_q   <= rd_word[7:0];
              rwds_q <= 1'b0;
              addr   <= next_addr(addr, is_lin);
            end
          end
          ST_WR: begin
            if (rise) begin
              wr_hi      <= dq_in;
              wr_mask_hi <= rwds_in;
            end else if (fall) begin
              addr <= next_addr(addr, is_lin);
            end
          end
          ST_REGWR: begin
            if (rise) wr_hi <= dq_in;
            else if (fall && byte_cnt == 3'd0) begin
              if (addr == 32'd1) cfg <= {wr_hi, dq_in};
              byte_cnt <= 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Memory reads continuously at addr, so the word is ready well before the next rise.
  assign mem_we = (state == ST_WR) && fall && !abort;

  hyper_resp_mem #(.WORDS(MEM_WORDS), .AW(AW)) u_mem (
    .clk_i (clk_i),
    .addr  (addr[AW-1:0]),
    .we    (mem_we),
    .be    ({~wr_mask_hi, ~rwds_in}),
    .wdata ({wr_hi, dq_in}),
    .rdata (mem_rdata)
  );

  always_comb begin
    rd_word = mem_rdata;
    if (is_reg) begin
      if (addr == 32'd0)      rd_word = ID0_VAL;
      else if (addr == 32'd1) rd_word = cfg;
      else                    rd_word = 16'h0000;
    end
  end

  always_comb begin
    hyper_o = '0;
    case (state)
      ST_CA: hyper_o.hyper_rwds_i = lat2x;
      ST_RD: begin
        hyper_o.hyper_rwds_i = rwds_q;
        hyper_o.hyper_dq_i   = dq_q;
      end
      default: ;
    endcase
  end

  assign dev_rwds_oe_o = (state == ST_CA) || (state == ST_LAT) || (state == ST_RD);
  assign dev_dq_oe_o   = (state == ST_RD);
  assign busy_o        = (state != ST_IDLE);

endmodule
